// File: rtl/cell_sweep_checker.sv
// ---------------------------------------------------------------------------
// cell_sweep_checker
//
// Clocked stimulus generator and response checker for a single-output
// combinational cell with N_IN inputs. After start it walks the input vector
// from 0 to 2**N_IN-1. Each vector is held for GAP cycles before it is applied
// and is then left to settle for SETTLE cycles. The cell output is then sampled
// and compared against the EXPECT truth table.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a sweep (sampled in IDLE or DONE only)
//   stim          registered stimulus to the cell inputs, MSB first
//   dut_zn        cell output under test (must be stable by the sample edge)
//   busy          high while a sweep is running (WAIT_GAP / SETTLE)
//   done          high once the sweep has finished
//   pass          with done: 1 when no vector mismatched
//   err_count     mismatching vectors in the current / last sweep
//   log_valid     one-cycle strobe per sampled vector
//   log_vec       vector index of the latest sample
//   log_zn        sampled dut_zn
//   log_mismatch  latest sample differed from EXPECT[log_vec]
// ---------------------------------------------------------------------------
module cell_sweep_checker #(
    parameter int                      N_IN   = 4,
    parameter int                      GAP    = 5,
    parameter int                      SETTLE = 10,
    parameter logic [(2**N_IN)-1:0]    EXPECT = 16'h0007
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_zn,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            log_valid,
    output logic [N_IN-1:0] log_vec,
    output logic            log_zn,
    output logic            log_mismatch
);

    // The timer only has to reach max(GAP,SETTLE)-1.
    localparam int TMAX = (GAP > SETTLE) ? GAP : SETTLE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] GAP_LAST    = TW'(GAP - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_GAP,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic              log_valid_q, log_valid_d;
    logic [N_IN-1:0]   log_vec_q, log_vec_d;
    logic              log_zn_q, log_zn_d;
    logic              log_mismatch_q, log_mismatch_d;

    logic              sample_mismatch;
    logic [N_IN:0]     err_count_inc;

    // Case inequality so that an X/Z output from a simulated cell model is
    // counted as a failure rather than silently matching.
    assign sample_mismatch = (dut_zn !== EXPECT[vec_q]);
    assign err_count_inc   = err_count_q + {{N_IN{1'b0}}, sample_mismatch};

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        timer_d        = timer_q;
        stim_d         = stim_q;
        busy_d         = busy_q;
        done_d         = done_q;
        pass_d         = pass_q;
        err_count_d    = err_count_q;
        log_valid_d    = 1'b0;
        log_vec_d      = log_vec_q;
        log_zn_d       = log_zn_q;
        log_mismatch_d = log_mismatch_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // stim deliberately keeps its last value until the first
                // vector of the new sweep is applied.
                if (start) begin
                    vec_d       = '0;
                    timer_d     = '0;
                    err_count_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_WAIT_GAP;
                end
            end

            S_WAIT_GAP: begin
                if (timer_q == GAP_LAST) begin
                    stim_d  = vec_q;
                    timer_d = '0;
                    state_d = S_SETTLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    log_valid_d    = 1'b1;
                    log_vec_d      = vec_q;
                    log_zn_d       = dut_zn;
                    log_mismatch_d = sample_mismatch;
                    err_count_d    = err_count_inc;
                    if (vec_q == {N_IN{1'b1}}) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_count_inc == '0);
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        timer_d = '0;
                        state_d = S_WAIT_GAP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            vec_q          <= '0;
            timer_q        <= '0;
            stim_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            err_count_q    <= '0;
            log_valid_q    <= 1'b0;
            log_vec_q      <= '0;
            log_zn_q       <= 1'b0;
            log_mismatch_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            timer_q        <= timer_d;
            stim_q         <= stim_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            err_count_q    <= err_count_d;
            log_valid_q    <= log_valid_d;
            log_vec_q      <= log_vec_d;
            log_zn_q       <= log_zn_d;
            log_mismatch_q <= log_mismatch_d;
        end
    end

    assign stim         = stim_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_count_q;
    assign log_valid    = log_valid_q;
    assign log_vec      = log_vec_q;
    assign log_zn       = log_zn_q;
    assign log_mismatch = log_mismatch_q;

endmodule
